// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants: datapath widths, PC step,
// and the fetch-buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Instruction addresses are word aligned; the low two bits are never used.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched instructions, with flush.
// Uses pointers one bit wider than the index so that full and empty are distinct.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: the storage array has no reset; validity lives entirely in the
    // pointers, and resetting a RAM-style array blocks memory inference.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // An empty FIFO presents zeros rather than stale storage contents.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation with redirect, feeding a
// fetch buffer toward decode. Optional counters under IFU_PERF_CNT_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall_cycles
`endif
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

    logic         [XLEN-1:0] fetch_pc;
    fetch_entry_t            push_entry;
    fetch_entry_t            head_entry;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    // A redirect squashes both the pop and the push of its cycle.
    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = !redirect_valid && (!fifo_full || pop);

    assign push_entry = '{pc: fetch_pc, instr: imem_instr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_INC;
        end
    end

    assign imem_addr = fetch_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (pop)                    perf_fetched      <= perf_fetched + 32'd1;
            if (out_valid && !out_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0 and
// 0xFFFFFFF8) checked against per-instance queues of expected fetches.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr ^ 32'hDEAD_BEEF) + 32'h0101_0101;
    endfunction

    // Instance 0: RESET_PC = 0
    logic        rst0, redir_valid0, ready0, out_valid0;
    logic [31:0] redir_pc0, imem_addr0, imem_instr0, out_instr0, out_pc0;
    // Instance 1: RESET_PC = 0xFFFFFFF8
    logic        rst1, redir_valid1, ready1, out_valid1;
    logic [31:0] redir_pc1, imem_addr1, imem_instr1, out_instr1, out_pc1;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched0, perf_stall0, perf_fetched1, perf_stall1;
`endif

    assign imem_instr0 = mem_word(imem_addr0);
    assign imem_instr1 = mem_word(imem_addr1);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut0 (
        .clk            (clk),
        .rst            (rst0),
        .imem_addr      (imem_addr0),
        .imem_instr     (imem_instr0),
        .redirect_valid (redir_valid0),
        .redirect_pc    (redir_pc0),
        .out_valid      (out_valid0),
        .out_ready      (ready0),
        .out_instr      (out_instr0),
        .out_pc         (out_pc0)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched0),
        .perf_stall_cycles (perf_stall0)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut1 (
        .clk            (clk),
        .rst            (rst1),
        .imem_addr      (imem_addr1),
        .imem_instr     (imem_instr1),
        .redirect_valid (redir_valid1),
        .redirect_pc    (redir_pc1),
        .out_valid      (out_valid1),
        .out_ready      (ready1),
        .out_instr      (out_instr1),
        .out_pc         (out_pc1)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched1),
        .perf_stall_cycles (perf_stall1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: expected PCs of accepted instructions, in order.
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic        mon0 = 1'b0;
    logic        mon1 = 1'b0;

    always @(negedge clk) begin
        if (mon0 && out_valid0 && ready0 && !redir_valid0) begin
            if (exp0.size() == 0) begin
                check("dut0_unexpected_pop", out_pc0, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] pc;
                pc = exp0.pop_front();
                check("dut0_pop_pc", out_pc0, pc);
                check("dut0_pop_instr", out_instr0, mem_word(pc));
            end
        end
        if (mon1 && out_valid1 && ready1 && !redir_valid1) begin
            if (exp1.size() == 0) begin
                check("dut1_unexpected_pop", out_pc1, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] pc;
                pc = exp1.pop_front();
                check("dut1_pop_pc", out_pc1, pc);
                check("dut1_pop_instr", out_instr1, mem_word(pc));
            end
        end
    end

    initial begin
        rst0 = 1'b1; redir_valid0 = 1'b0; redir_pc0 = '0; ready0 = 1'b0;
        rst1 = 1'b1; redir_valid1 = 1'b0; redir_pc1 = '0; ready1 = 1'b0;
        repeat (2) step();

        // Reset state
        check("rst_imem_addr0", imem_addr0, 32'h0);
        check("rst_out_valid0", {31'b0, out_valid0}, 32'h0);
        check("rst_out_pc0", out_pc0, 32'h0);
        check("rst_out_instr0", out_instr0, 32'h0);
        check("rst_imem_addr1", imem_addr1, 32'hFFFF_FFF8);
        check("rst_out_valid1", {31'b0, out_valid1}, 32'h0);

        // Streaming from reset at one instruction per cycle
        mon0 = 1'b1;
        exp0.push_back(32'h0); exp0.push_back(32'h4);
        exp0.push_back(32'h8); exp0.push_back(32'hC);
        rst0 = 1'b0; ready0 = 1'b1;
        repeat (5) step();
        ready0 = 1'b0;
        check("stream_drained", 32'(exp0.size()), 32'd0);

        // Asynchronous reset with an entry buffered
        #2 rst0 = 1'b1;
        #1;
        check("async_rst_valid0", {31'b0, out_valid0}, 32'h0);
        check("async_rst_addr0", imem_addr0, 32'h0);
        rst0 = 1'b0;

        // Back-pressure from the first cycle: buffer fills, fetch stalls at 0x8
        repeat (4) step();
        check("stall_imem_addr", imem_addr0, 32'h8);
        check("stall_valid", {31'b0, out_valid0}, 32'h1);
        check("stall_out_pc", out_pc0, 32'h0);
        check("stall_out_instr", out_instr0, mem_word(32'h0));
        repeat (2) step();
        check("stall_hold_pc", out_pc0, 32'h0);
        check("stall_hold_instr", out_instr0, mem_word(32'h0));
        check("stall_hold_addr", imem_addr0, 32'h8);
        exp0.push_back(32'h0); exp0.push_back(32'h4); exp0.push_back(32'h8);
        ready0 = 1'b1;
        repeat (3) step();
        ready0 = 1'b0;
        check("release_drained", 32'(exp0.size()), 32'd0);

        // Redirect while the buffer holds 0x4 and 0x8, coinciding with a pop
        rst0 = 1'b1;
        #2 rst0 = 1'b0;
        repeat (3) step();
        exp0.push_back(32'h0);
        ready0 = 1'b1;
        step();
        ready0 = 1'b0;
        check("pre_redir_drained", 32'(exp0.size()), 32'd0);
        check("pre_redir_head", out_pc0, 32'h4);
        check("pre_redir_addr", imem_addr0, 32'hC);
        redir_valid0 = 1'b1; redir_pc0 = 32'h23; ready0 = 1'b1;
        step();
        redir_valid0 = 1'b0;
        check("redir_valid_low", {31'b0, out_valid0}, 32'h0);
        check("redir_addr_aligned", imem_addr0, 32'h20);
`ifdef IFU_PERF_CNT_EN
        check("redir_pop_not_counted", perf_fetched0, 32'd1);
`endif
        exp0.push_back(32'h20); exp0.push_back(32'h24);
        repeat (3) step();
        ready0 = 1'b0;
        check("post_redir_drained", 32'(exp0.size()), 32'd0);

`ifdef IFU_PERF_CNT_EN
        // 10 accepted instructions followed by 3 stall cycles
        mon0 = 1'b0;
        rst0 = 1'b1;
        #2 rst0 = 1'b0;
        check("perf_rst_fetched", perf_fetched0, 32'd0);
        check("perf_rst_stall", perf_stall0, 32'd0);
        ready0 = 1'b1;
        repeat (11) step();
        ready0 = 1'b0;
        repeat (3) step();
        check("perf_fetched", perf_fetched0, 32'd10);
        check("perf_stall", perf_stall0, 32'd3);
`endif

        // Address wrap from the top of the address space
        mon1 = 1'b1;
        exp1.push_back(32'hFFFF_FFF8); exp1.push_back(32'hFFFF_FFFC); exp1.push_back(32'h0);
        rst1 = 1'b0; ready1 = 1'b1;
        repeat (4) step();
        ready1 = 1'b0;
        check("wrap_drained", 32'(exp1.size()), 32'd0);

        // Reset pulsed between clock edges mid-stream, then restart
        step();
        check("pre_pulse_valid1", {31'b0, out_valid1}, 32'h1);
        #2 rst1 = 1'b1;
        #1;
        check("pulse_valid1", {31'b0, out_valid1}, 32'h0);
        check("pulse_addr1", imem_addr1, 32'hFFFF_FFF8);
        check("pulse_out_pc1", out_pc1, 32'h0);
        #1 rst1 = 1'b0;
        exp1.push_back(32'hFFFF_FFF8); exp1.push_back(32'hFFFF_FFFC);
        ready1 = 1'b1;
        repeat (3) step();
        ready1 = 1'b0;
        check("restart_drained", 32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
